// File: rtl/video_timing_gen_pkg.sv
// Shared types for the raster timing generator: phase FSM encoding, the
// register bundle and the phase-step helper used by both axes.
package video_timing_gen_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    typedef struct packed {
        phase_t      nxt;
        logic [11:0] last;
    } phase_step_t;

    // Sync bits hold the asserted state; polarity is applied at the port.
    typedef struct packed {
        logic [11:0] h_cnt;
        logic [10:0] v_cnt;
        phase_t      h_phase;
        phase_t      v_phase;
        logic        hsync;
        logic        vsync;
        logic        de;
        logic [10:0] x;
        logic [9:0]  y;
        logic        line_start;
        logic        frame_start;
    } vtg_regs_t;

    localparam vtg_regs_t VTG_RESET = '{
        h_cnt:       12'd0,
        v_cnt:       11'd0,
        h_phase:     ACTIVE,
        v_phase:     ACTIVE,
        hsync:       1'b0,
        vsync:       1'b0,
        de:          1'b0,
        x:           11'd0,
        y:           10'd0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    // Last count belonging to phase ph, and the phase that follows it.
    // Zero-length porches/syncs are skipped; the active phase is never empty.
    function automatic phase_step_t phase_step(input phase_t ph, input int a,
                                               input int f, input int s, input int b);
        int     len [4];
        int     end_c;
        phase_t nx;
        phase_t cand;
        logic   found;
        len[0] = a;
        len[1] = f;
        len[2] = s;
        len[3] = b;
        end_c  = 0;
        for (int i = 0; i < 4; i++)
            if (i <= int'(ph)) end_c += len[i];
        nx    = ph;
        found = 1'b0;
        for (int i = 1; i < 4; i++) begin
            cand = phase_t'(2'(int'(ph) + i));
            if (!found && len[int'(cand)] != 0) begin
                nx    = cand;
                found = 1'b1;
            end
        end
        return '{nxt: nx, last: 12'(end_c - 1)};
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator: phase FSMs on both axes, outputs registered from
// the decode of the current counters, so outputs lag the counters by one cycle.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int   H_ACTIVE = 1366,
    parameter int   H_FRONT  = 70,
    parameter int   H_SYNC   = 143,
    parameter int   H_BACK   = 213,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FRONT  = 3,
    parameter int   V_SYNC   = 3,
    parameter int   V_BACK   = 24,
    parameter logic SYNC_POS = 1'b1
) (
    input  logic        i_nrst,
    input  logic        i_clk,
    input  logic        i_en,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [10:0] o_x,
    output logic [9:0]  o_y,
    output logic        o_line_start,
    output logic        o_frame_start
);

    localparam int HT       = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT       = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HSS      = H_ACTIVE + H_FRONT;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    // With no back porch the vsync tail lands on line 0 of the next frame.
    localparam int VS_TAIL  = (VS_END >= VT) ? 0 : VS_END;

    generate
        if (HT > 4095 || VT > 2047 || H_ACTIVE < 1 || H_ACTIVE > 2047 ||
            V_ACTIVE < 1 || V_ACTIVE > 1023) begin : g_bad_timing
            $error("video_timing_gen: timing parameters out of range");
        end
    endgenerate

    vtg_regs_t   r, r_nxt;
    phase_step_t hstep, vstep;
    logic        h_wrap, v_wrap;

    always_comb begin
        hstep  = phase_step(r.h_phase, H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
        vstep  = phase_step(r.v_phase, V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
        h_wrap = (r.h_cnt == 12'(HT - 1));
        v_wrap = (r.v_cnt == 11'(VT - 1));
        r_nxt  = r;

        r_nxt.de          = (r.h_phase == ACTIVE) && (r.v_phase == ACTIVE);
        r_nxt.x           = r_nxt.de ? r.h_cnt[10:0] : 11'd0;
        r_nxt.y           = (r.v_phase == ACTIVE) ? r.v_cnt[9:0] : 10'd0;
        r_nxt.hsync       = (r.h_phase == SYNC);
        // vsync edges sit on the hsync leading edge of the first and the
        // first-after-last sync lines.
        r_nxt.vsync       = ((r.v_phase == SYNC) &&
                             (r.v_cnt != 11'(VS_START) || r.h_cnt >= 12'(HSS))) ||
                            ((V_SYNC > 0) && r.v_cnt == 11'(VS_TAIL) && r.h_cnt < 12'(HSS));
        r_nxt.line_start  = (r.h_cnt == 12'd0) && (r.v_phase == ACTIVE);
        r_nxt.frame_start = (r.h_cnt == 12'd0) && (r.v_cnt == 11'd0);

        if (r.h_cnt == hstep.last) r_nxt.h_phase = hstep.nxt;
        r_nxt.h_cnt = h_wrap ? 12'd0 : r.h_cnt + 12'd1;
        if (h_wrap) begin
            if ({1'b0, r.v_cnt} == vstep.last) r_nxt.v_phase = vstep.nxt;
            r_nxt.v_cnt = v_wrap ? 11'd0 : r.v_cnt + 11'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)    r <= VTG_RESET;
        else if (!i_en) r <= VTG_RESET;
        else            r <= r_nxt;
    end

    assign o_hsync       = r.hsync ^ ~SYNC_POS;
    assign o_vsync       = r.vsync ^ ~SYNC_POS;
    assign o_de          = r.de;
    assign o_x           = r.x;
    assign o_y           = r.y;
    assign o_line_start  = r.line_start;
    assign o_frame_start = r.frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: small-timing instance (A) and default-timing active-low instance (B),
// both checked every cycle against an arithmetic raster model.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst_a, en_a, nrst_b, en_b;
    logic hs_a, vs_a, de_a, ls_a, fs_a;
    logic [10:0] x_a;
    logic [9:0]  y_a;
    logic hs_b, vs_b, de_b, ls_b, fs_b;
    logic [10:0] x_b;
    logic [9:0]  y_b;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POS(1'b1)
    ) u_a (
        .i_nrst(nrst_a), .i_clk(clk), .i_en(en_a),
        .o_hsync(hs_a), .o_vsync(vs_a), .o_de(de_a), .o_x(x_a), .o_y(y_a),
        .o_line_start(ls_a), .o_frame_start(fs_a)
    );

    video_timing_gen #(.SYNC_POS(1'b0)) u_b (
        .i_nrst(nrst_b), .i_clk(clk), .i_en(en_b),
        .o_hsync(hs_b), .o_vsync(vs_b), .o_de(de_b), .o_x(x_b), .o_y(y_b),
        .o_line_start(ls_b), .o_frame_start(fs_b)
    );

    int tests = 0;
    int fails = 0;

    // Vector layout: [25]hs [24]vs [23]de [22:12]x [11:2]y [1]ls [0]fs
    wire [25:0] vec_a = {hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a};
    wire [25:0] vec_b = {hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b};

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // n = index of the enabled edge since the last restart (-1: reset state).
    function automatic logic [25:0] expv(input int n, input int ha, input int hf,
                                         input int hsw, input int hb, input int va,
                                         input int vf, input int vsw, input int vb,
                                         input logic sp);
        int ht, vt, m, h, v, st, et;
        logic de, hsa, vsa, ls, fs;
        logic [10:0] x;
        logic [9:0]  y;
        if (n < 0) return {~sp, ~sp, 24'd0};
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        m   = n % (ht * vt);
        h   = m % ht;
        v   = m / ht;
        de  = (h < ha) && (v < va);
        x   = de ? 11'(h) : 11'd0;
        y   = (v < va) ? 10'(v) : 10'd0;
        hsa = (h >= ha + hf) && (h < ha + hf + hsw);
        st  = (va + vf) * ht + ha + hf;
        et  = st + vsw * ht;
        vsa = (m >= st && m < et) || (m + ht * vt < et);
        ls  = (h == 0) && (v < va);
        fs  = (m == 0);
        return {hsa ^ ~sp, vsa ^ ~sp, de, x, y, ls, fs};
    endfunction

    function automatic int f_hs(input logic [25:0] v); return int'(v[25]); endfunction
    function automatic int f_vs(input logic [25:0] v); return int'(v[24]); endfunction
    function automatic int f_de(input logic [25:0] v); return int'(v[23]); endfunction
    function automatic int f_x (input logic [25:0] v); return int'(v[22:12]); endfunction
    function automatic int f_y (input logic [25:0] v); return int'(v[11:2]); endfunction
    function automatic int f_ls(input logic [25:0] v); return int'(v[1]); endfunction
    function automatic int f_fs(input logic [25:0] v); return int'(v[0]); endfunction

    int n_a = -1;
    int n_b = -1;
    always @(posedge clk or negedge nrst_a)
        if (!nrst_a)    n_a <= -1;
        else if (!en_a) n_a <= -1;
        else            n_a <= n_a + 1;
    always @(posedge clk or negedge nrst_b)
        if (!nrst_b)    n_b <= -1;
        else if (!en_b) n_b <= -1;
        else            n_b <= n_b + 1;

    logic [25:0] tr_a [300];
    logic [25:0] tr_b [4000];

    always @(negedge clk) begin
        chk("A_cycle", vec_a, expv(n_a, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1));
        chk("B_cycle", vec_b, expv(n_b, 1366, 70, 143, 213, 768, 3, 3, 24, 1'b0));
        if (n_a >= 0 && n_a < 300)  tr_a[n_a] = vec_a;
        if (n_b >= 0 && n_b < 4000) tr_b[n_b] = vec_b;
    end

    initial begin
        int cnt, mx;
        logic found;
        nrst_a = 1'b0; en_a = 1'b1;
        nrst_b = 1'b0; en_b = 1'b1;
        #3;
        chk("reset_vec_a", vec_a, 0);
        chk("reset_hs_b", hs_b, 1);
        chk("reset_vs_b", vs_b, 1);
        @(negedge clk);
        nrst_a = 1'b1;
        nrst_b = 1'b1;
        @(negedge clk);
        // First enabled edge: origin pixel, both start pulses, syncs idle.
        chk("first_edge_a", vec_a, {1'b0, 1'b0, 1'b1, 11'd0, 10'd0, 1'b1, 1'b1});
        repeat (299) @(negedge clk);

        cnt = 0;
        for (int k = 0; k < 16; k++) cnt += f_de(tr_a[k]);
        chk("de_per_line", cnt, 8);
        cnt = 0;
        for (int k = 0; k < 8; k++) if (f_x(tr_a[k]) != k || f_de(tr_a[k]) != 1) cnt++;
        chk("x_ramp_bad", cnt, 0);
        chk("de_k8", f_de(tr_a[8]), 0);
        cnt = 0;
        for (int k = 0; k < 16; k++) cnt += f_hs(tr_a[k]);
        chk("hs_width", cnt, 3);
        chk("hs_k9", f_hs(tr_a[9]), 0);
        chk("hs_k10", f_hs(tr_a[10]), 1);
        chk("hs_k12", f_hs(tr_a[12]), 1);
        chk("hs_k13", f_hs(tr_a[13]), 0);
        cnt = 0;
        for (int k = 0; k < 128; k++) cnt += f_ls(tr_a[k]);
        chk("ls_count_frame", cnt, 4);
        chk("ls_k48", f_ls(tr_a[48]), 1);
        chk("ls_k64", f_ls(tr_a[64]), 0);
        chk("vs_k89", f_vs(tr_a[89]), 0);
        chk("vs_k90", f_vs(tr_a[90]), 1);
        chk("vs_k121", f_vs(tr_a[121]), 1);
        chk("vs_k122", f_vs(tr_a[122]), 0);
        cnt = 0;
        for (int k = 1; k < 128; k++) cnt += f_fs(tr_a[k]);
        chk("fs_gap", cnt, 0);
        chk("fs_k128", f_fs(tr_a[128]), 1);
        mx = 0;
        for (int k = 64; k < 128; k++) if (f_y(tr_a[k]) > mx) mx = f_y(tr_a[k]);
        chk("y_vblank", mx, 0);
        chk("y_k50", f_y(tr_a[50]), 3);

        // Drop enable with the counters at h=5, v=2.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (n_a % 128 == 36) found = 1'b1;
            else @(negedge clk);
        end
        chk("wait_h5v2", found, 1);
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("en_low_vec", vec_a, 0);
        end
        en_a = 1'b1;
        @(negedge clk);
        chk("reen_fs", fs_a, 1);
        chk("reen_x", x_a, 0);
        chk("reen_y", y_a, 0);
        repeat (128) @(negedge clk);
        chk("reen_next_fs", fs_a, 1);

        // Async reset while hsync is asserted.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (hs_a) found = 1'b1;
            else @(negedge clk);
        end
        chk("wait_hsync", found, 1);
        #2 nrst_a = 1'b0;
        #1;
        chk("arst_hs", hs_a, 0);
        chk("arst_de", de_a, 0);
        chk("arst_x", x_a, 0);
        @(negedge clk);
        nrst_a = 1'b1;
        @(negedge clk);
        chk("arst_restart", vec_a, {1'b0, 1'b0, 1'b1, 11'd0, 10'd0, 1'b1, 1'b1});

        // Random enable drops and async reset pulses on A.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            en_a = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 59) == 0) begin
                #2 nrst_a = 1'b0;
                #1 nrst_a = 1'b1;
            end
        end
        en_a = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            if (n_b >= 3700) found = 1'b1;
            else @(negedge clk);
        end
        chk("wait_b_lines", found, 1);
        chk("b_hs_k1435", f_hs(tr_b[1435]), 1);
        chk("b_hs_k1436", f_hs(tr_b[1436]), 0);
        chk("b_hs_k1578", f_hs(tr_b[1578]), 0);
        chk("b_hs_k1579", f_hs(tr_b[1579]), 1);
        cnt = 0;
        for (int k = 0; k < 1792; k++) cnt += 1 - f_hs(tr_b[k]);
        chk("b_hs_low_cycles", cnt, 143);
        chk("b_ls_k1791", f_ls(tr_b[1791]), 0);
        chk("b_ls_k1792", f_ls(tr_b[1792]), 1);
        chk("b_x_k1365", f_x(tr_b[1365]), 1365);
        chk("b_de_k1366", f_de(tr_b[1366]), 0);
        chk("b_y_k3600", f_y(tr_b[3600]), 2);
        chk("b_vs_idle", f_vs(tr_b[2000]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
